// File: rtl/mmio_pkg.sv
// Shared bus definitions for memory-mapped peripherals: width encodings,
// timer register offsets, CTRL bit positions and byte-lane helpers.
package mmio_pkg;

    localparam logic [1:0] BYTE = 2'd0;
    localparam logic [1:0] HALF = 2'd1;
    localparam logic [1:0] WORD = 2'd2;

    localparam int WINDOW_BYTES = 64;

    localparam logic [5:0] OFF_CTRL     = 6'h00;
    localparam logic [5:0] OFF_PRESCALE = 6'h04;
    localparam logic [5:0] OFF_COUNT    = 6'h08;
    localparam logic [5:0] OFF_STATUS   = 6'h0C;
    localparam logic [5:0] OFF_IRQ_EN   = 6'h10;
    localparam logic [5:0] OFF_COMPARE  = 6'h20;

    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_PERIODIC = 1;

    // Lanes above byte 3 fall off the word: a misaligned store is truncated.
    function automatic logic [3:0] byte_mask(input logic [1:0] width, input logic [1:0] lane);
        logic [3:0] mask;
        case (width)
            BYTE:    mask = 4'b0001 << lane;
            HALF:    mask = 4'b0011 << lane;
            WORD:    mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  mask);
        logic [31:0] merged;
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = mask[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/mmio_prescaler.sv
// Divides the clock into a one-cycle tick every reload+1 cycles while enabled.
module mmio_prescaler (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        restart,
    input  logic [31:0] reload,
    output logic        tick
);

    logic [31:0] pcnt;

    // A restart (reload value being rewritten) suppresses the tick of that cycle.
    assign tick = enable && !restart && (pcnt == reload);

    always_ff @(posedge clock) begin
        if (reset) begin
            pcnt <= '0;
        end else if (!enable || restart || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 32'd1;
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped timer: prescaled up-counter, CHANNELS compare channels with
// sticky match flags, and a level interrupt from STATUS & IRQ_EN.
module mmio_timer
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR        = 32'h4000_0100,
    parameter int          CHANNELS         = 4,
    parameter logic [31:0] DEFAULT_PRESCALE = 32'd100
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [1:0]  data_width,
    input  logic [31:0] write_data,
    input  logic        read,
    input  logic        write,
    output logic [31:0] read_data,
    output logic        selected,
    output logic        irq
);

    // Bus strobes: read and write are single-cycle qualifiers with no backpressure;
    // a store commits at the edge where write && selected, a load is answered in the same cycle.
    logic [31:0] rel_addr;
    logic [5:0]  word_off;
    logic [1:0]  lane;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic        wr;
    logic        wr_ctrl, wr_prescale, wr_count, wr_status, wr_irq_en;

    logic        enable, periodic;
    logic [31:0] prescale, count;
    logic [31:0] compare [CHANNELS];
    logic [CHANNELS-1:0] status, irq_en, match, w1c, wr_compare;
    logic        tick;
    logic [31:0] reg_word;

    // Unsigned wrap makes addresses below the base compare as huge offsets.
    assign rel_addr = address - BASE_ADDR;
    assign selected = rel_addr < 32'(WINDOW_BYTES);
    assign word_off = {rel_addr[5:2], 2'b00};
    assign lane     = address[1:0];
    assign wmask    = byte_mask(data_width, lane);
    assign wdata    = write_data << {lane, 3'b000};
    assign wr       = write && selected;

    assign wr_ctrl     = wr && (word_off == OFF_CTRL);
    assign wr_prescale = wr && (word_off == OFF_PRESCALE);
    assign wr_count    = wr && (word_off == OFF_COUNT);
    assign wr_status   = wr && (word_off == OFF_STATUS);
    assign wr_irq_en   = wr && (word_off == OFF_IRQ_EN);

    assign w1c = (wr_status && wmask[0]) ? wdata[CHANNELS-1:0] : '0;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        assign wr_compare[i] = wr && (word_off == OFF_COMPARE + 6'(4 * i));
        // A software write to COUNT takes over the tick, so nothing matches then.
        assign match[i] = tick && !wr_count && (count == compare[i]);
    end

    mmio_prescaler u_prescaler (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .restart (wr_prescale),
        .reload  (prescale),
        .tick    (tick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            enable   <= 1'b0;
            periodic <= 1'b0;
            prescale <= DEFAULT_PRESCALE;
            count    <= '0;
            irq_en   <= '0;
            status   <= '0;
        end else begin
            if (wr_ctrl && wmask[0]) begin
                enable   <= wdata[CTRL_ENABLE];
                periodic <= wdata[CTRL_PERIODIC];
            end
            if (wr_prescale) begin
                prescale <= lane_merge(prescale, wdata, wmask);
            end
            if (wr_count) begin
                count <= lane_merge(count, wdata, wmask);
            end else if (tick) begin
                count <= (periodic && count == compare[0]) ? '0 : count + 32'd1;
            end
            if (wr_irq_en && wmask[0]) begin
                irq_en <= wdata[CHANNELS-1:0];
            end
            status <= match | (status & ~w1c);
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (reset) begin
                compare[i] <= '1;
            end else if (wr_compare[i]) begin
                compare[i] <= lane_merge(compare[i], wdata, wmask);
            end
        end
    end

    always_comb begin
        reg_word = '0;
        case (word_off)
            OFF_CTRL:     reg_word = {30'b0, periodic, enable};
            OFF_PRESCALE: reg_word = prescale;
            OFF_COUNT:    reg_word = count;
            OFF_STATUS:   reg_word = 32'(status);
            OFF_IRQ_EN:   reg_word = 32'(irq_en);
            default:      reg_word = '0;
        endcase
        for (int i = 0; i < CHANNELS; i++) begin
            if (word_off == OFF_COMPARE + 6'(4 * i)) begin
                reg_word = compare[i];
            end
        end
    end

    assign read_data = (read && selected) ? (reg_word >> {lane, 3'b000}) : '0;
    assign irq       = |(status & irq_en);

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: table-driven register reads plus
// hand-timed sequences for counting, periodic matches, wrap and collisions.
module tb_mmio_timer;
    import mmio_pkg::*;

    localparam logic [31:0] BASE = 32'h4000_0100;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  width;
        logic        rd;
        logic [31:0] exp_data;
        logic        exp_sel;
    } vec_t;

    typedef struct {
        logic [31:0] count;
        logic        irq;
    } seq_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [1:0]  data_width;
    logic [31:0] write_data;
    logic        read;
    logic        write;
    logic [31:0] read_data;
    logic        selected;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    vec_t rst_tab[13];
    seq_t per_tab[7];

    mmio_timer #(
        .BASE_ADDR        (BASE),
        .CHANNELS         (4),
        .DEFAULT_PRESCALE (32'd100)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .address    (address),
        .data_width (data_width),
        .write_data (write_data),
        .read       (read),
        .write      (write),
        .read_data  (read_data),
        .selected   (selected),
        .irq        (irq)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic vec_t mk(input logic [31:0] addr, input logic [1:0] width,
                                input logic rd, input logic [31:0] exp_data, input logic exp_sel);
        vec_t v;
        v.addr = addr;
        v.width = width;
        v.rd = rd;
        v.exp_data = exp_data;
        v.exp_sel = exp_sel;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_irq(input string name, input logic exp);
        chk(name, {31'b0, irq}, {31'b0, exp});
    endtask

    // Zero-time load: sampled 1ns after the negedge it is driven on.
    task automatic peek(input string name, input logic [5:0] off, input logic [1:0] width,
                        input logic [31:0] exp);
        exp_q.push_back(exp);
        address = BASE + 32'(off);
        data_width = width;
        read = 1'b1;
        #1;
        chk(name, read_data, exp_q.pop_front());
        read = 1'b0;
    endtask

    task automatic rd(input string name, input logic [5:0] off, input logic [1:0] width,
                      input logic [31:0] exp);
        peek(name, off, width, exp);
        @(negedge clock);
    endtask

    task automatic wr_abs(input logic [31:0] addr, input logic [1:0] width, input logic [31:0] data);
        address = addr;
        data_width = width;
        write_data = data;
        write = 1'b1;
        @(negedge clock);
        write = 1'b0;
    endtask

    task automatic wr(input logic [5:0] off, input logic [1:0] width, input logic [31:0] data);
        wr_abs(BASE + 32'(off), width, data);
    endtask

    task automatic run_reset_table(input string tag);
        for (int i = 0; i < 13; i++) begin
            exp_q.push_back(rst_tab[i].exp_data);
            address = rst_tab[i].addr;
            data_width = rst_tab[i].width;
            read = rst_tab[i].rd;
            #1;
            chk($sformatf("%s[%0d] data", tag, i), read_data, exp_q.pop_front());
            chk($sformatf("%s[%0d] sel", tag, i), {31'b0, selected}, {31'b0, rst_tab[i].exp_sel});
            read = 1'b0;
            @(negedge clock);
        end
        chk_irq({tag, " irq"}, 1'b0);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] e;

        rst_tab[0]  = mk(BASE + 32'h00, WORD, 1'b1, 32'h0000_0000, 1'b1);
        rst_tab[1]  = mk(BASE + 32'h04, WORD, 1'b1, 32'd100,       1'b1);
        rst_tab[2]  = mk(BASE + 32'h08, WORD, 1'b1, 32'h0000_0000, 1'b1);
        rst_tab[3]  = mk(BASE + 32'h0C, WORD, 1'b1, 32'h0000_0000, 1'b1);
        rst_tab[4]  = mk(BASE + 32'h10, WORD, 1'b1, 32'h0000_0000, 1'b1);
        rst_tab[5]  = mk(BASE + 32'h20, WORD, 1'b1, 32'hFFFF_FFFF, 1'b1);
        rst_tab[6]  = mk(BASE + 32'h24, WORD, 1'b1, 32'hFFFF_FFFF, 1'b1);
        rst_tab[7]  = mk(BASE + 32'h2C, WORD, 1'b1, 32'hFFFF_FFFF, 1'b1);
        rst_tab[8]  = mk(BASE + 32'h30, WORD, 1'b1, 32'h0000_0000, 1'b1);
        rst_tab[9]  = mk(BASE + 32'h04, WORD, 1'b0, 32'h0000_0000, 1'b1);
        rst_tab[10] = mk(BASE + 32'h40, WORD, 1'b1, 32'h0000_0000, 1'b0);
        rst_tab[11] = mk(BASE - 32'h04, WORD, 1'b1, 32'h0000_0000, 1'b0);
        rst_tab[12] = mk(BASE + 32'h23, BYTE, 1'b1, 32'h0000_00FF, 1'b1);

        per_tab[0] = '{32'd0, 1'b0};
        per_tab[1] = '{32'd1, 1'b0};
        per_tab[2] = '{32'd2, 1'b0};
        per_tab[3] = '{32'd3, 1'b0};
        per_tab[4] = '{32'd4, 1'b0};
        per_tab[5] = '{32'd0, 1'b1};
        per_tab[6] = '{32'd1, 1'b1};

        // Clock/reset
        reset = 1'b1;
        address = '0;
        data_width = WORD;
        write_data = '0;
        read = 1'b0;
        write = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        run_reset_table("reset");

        // Prescale 3: tick every 4 cycles, 40 cycles of running gives about 10
        wr(OFF_PRESCALE, WORD, 32'd3);
        wr(OFF_CTRL, WORD, 32'd1);
        repeat (40) @(negedge clock);
        exp_q.push_back(32'd10);
        address = BASE + 32'(OFF_COUNT);
        data_width = WORD;
        read = 1'b1;
        #1;
        got = read_data;
        read = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (got < e - 32'd1 || got > e + 32'd1) begin
            errors++;
            $display("FAIL prescale3 count: got %0d expected %0d +-1", got, e);
        end

        // Prescale 0: one count per cycle
        wr(OFF_CTRL, WORD, 32'd0);
        wr(OFF_PRESCALE, WORD, 32'd0);
        wr(OFF_COUNT, WORD, 32'd100);
        wr(OFF_CTRL, WORD, 32'd1);
        for (int j = 0; j < 4; j++) begin
            rd($sformatf("prescale0 count[%0d]", j), OFF_COUNT, WORD, 32'd100 + 32'(j));
        end

        // Periodic mode with interrupt on channel 0
        wr(OFF_CTRL, WORD, 32'd0);
        wr(OFF_COUNT, WORD, 32'd0);
        wr(OFF_COMPARE, WORD, 32'd4);
        wr(OFF_IRQ_EN, WORD, 32'd1);
        wr(OFF_STATUS, WORD, 32'hF);
        wr(OFF_CTRL, WORD, 32'd3);
        for (int j = 0; j < 7; j++) begin
            peek($sformatf("periodic count[%0d]", j), OFF_COUNT, WORD, per_tab[j].count);
            chk_irq($sformatf("periodic irq[%0d]", j), per_tab[j].irq);
            @(negedge clock);
        end
        rd("periodic status", OFF_STATUS, WORD, 32'd1);
        wr(OFF_STATUS, WORD, 32'd1);
        peek("w1c status", OFF_STATUS, WORD, 32'd0);
        chk_irq("w1c irq", 1'b0);
        peek("w1c count", OFF_COUNT, WORD, 32'd4);
        // Clear lands on the tick that re-matches: the set must win
        wr(OFF_STATUS, WORD, 32'd1);
        peek("w1c+match status", OFF_STATUS, WORD, 32'd1);
        chk_irq("w1c+match irq", 1'b1);

        // Wrap through 32'hFFFF_FFFF
        wr(OFF_CTRL, WORD, 32'd0);
        wr(OFF_STATUS, WORD, 32'hF);
        wr(OFF_COUNT, WORD, 32'hFFFF_FFFE);
        wr(OFF_CTRL, WORD, 32'd1);
        rd("wrap count0", OFF_COUNT, WORD, 32'hFFFF_FFFE);
        rd("wrap count1", OFF_COUNT, WORD, 32'hFFFF_FFFF);
        rd("wrap count2", OFF_COUNT, WORD, 32'h0000_0000);
        rd("wrap count3", OFF_COUNT, WORD, 32'h0000_0001);
        peek("wrap status", OFF_STATUS, WORD, 32'hE);
        chk_irq("wrap irq", 1'b0);

        // Byte lanes
        wr(OFF_CTRL, WORD, 32'd0);
        wr(OFF_COMPARE, WORD, 32'hFFFF_FFFF);
        wr(6'h21, BYTE, 32'h0000_00AB);
        rd("byte store cmp0", OFF_COMPARE, WORD, 32'hFFFF_ABFF);
        rd("half load 0x22", 6'h22, HALF, 32'h0000_FFFF);
        rd("byte load 0x21", 6'h21, BYTE, 32'h00FF_FFAB);
        wr(6'h26, HALF, 32'h0000_1234);
        rd("half store cmp1", 6'h24, WORD, 32'h1234_FFFF);
        wr(6'h05, BYTE, 32'h0000_0001);
        rd("byte store prescale", OFF_PRESCALE, WORD, 32'h0000_0100);
        wr(6'h14, WORD, 32'hDEAD_BEEF);
        rd("unmapped write", 6'h14, WORD, 32'h0000_0000);
        wr_abs(BASE + 32'h40, WORD, 32'd3);
        rd("outside write", OFF_CTRL, WORD, 32'h0000_0000);

        // COUNT write in a tick cycle that would have matched channel 1
        wr(OFF_PRESCALE, WORD, 32'd0);
        wr(OFF_STATUS, WORD, 32'hF);
        wr(6'h24, WORD, 32'd10);
        wr(OFF_COUNT, WORD, 32'd8);
        wr(OFF_CTRL, WORD, 32'd1);
        repeat (2) @(negedge clock);
        peek("pre-collision count", OFF_COUNT, WORD, 32'd10);
        wr(OFF_COUNT, WORD, 32'd50);
        peek("collision count", OFF_COUNT, WORD, 32'd50);
        peek("collision status", OFF_STATUS, WORD, 32'd0);

        // Reset wins over a concurrent store
        wr(OFF_IRQ_EN, WORD, 32'hF);
        address = BASE + 32'(OFF_COUNT);
        data_width = WORD;
        write_data = 32'd1234;
        write = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        write = 1'b0;
        reset = 1'b0;
        run_reset_table("midreset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
